// File: rtl/adat_decoder.sv
// ADAT receive framer: hunts for frame sync, strips nibble separators and
// streams sample bits into the circular frame RAM, publishing good frames.
module adat_decoder #(
  parameter int CIRC_BUF_BITS = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       bit_i,
  input  logic                       bit_valid_i,
  output logic [CIRC_BUF_BITS+7:0]   ram_write_addr_o,
  output logic                       ram_data_o,
  output logic                       ram_we_o,
  output logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o,
  output logic [3:0]                 user_bits_o,
  output logic                       frame_done_o,
  output logic                       frame_error_o,
  output logic                       locked_o
);

  localparam int SW = CIRC_BUF_BITS;

  typedef enum logic [1:0] {
    StHunt,
    StUser,
    StSamples,
    StSync
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    zcnt_q, zcnt_d;
  logic [3:0]    scnt_q, scnt_d;
  logic [2:0]    nib_q, nib_d;
  logic [3:0]    user_q, user_d;
  logic [2:0]    ch_q, ch_d;
  logic [4:0]    bit_q, bit_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [SW-1:0] idx_q, idx_d;
  logic [3:0]    ubits_q, ubits_d;
  logic          we_q, we_d;
  logic          data_q, data_d;
  logic [SW+7:0] addr_q, addr_d;
  logic          pend_q, pend_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          good_q, good_d;
  logic          lock_q, lock_d;

  always_comb begin
    state_d = state_q;
    zcnt_d  = zcnt_q;
    scnt_d  = scnt_q;
    nib_d   = nib_q;
    user_d  = user_q;
    ch_d    = ch_q;
    bit_d   = bit_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    pend_d  = 1'b0;
    err_d   = 1'b0;
    if (bit_valid_i) begin
      unique case (state_q)
        StHunt: begin
          if (!bit_i) begin
            if (zcnt_q != 4'd15) begin
              zcnt_d = zcnt_q + 4'd1;
            end
          end else if (zcnt_q >= 4'd10) begin
            state_d = StUser;
            nib_d   = 3'd1;
            zcnt_d  = 4'd0;
          end else begin
            zcnt_d = 4'd0;
          end
        end
        StUser: begin
          // shift right so the first user bit lands in bit 0
          user_d = {bit_i, user_q[3:1]};
          if (nib_q == 3'd4) begin
            state_d = StSamples;
            nib_d   = 3'd0;
            ch_d    = 3'd0;
            bit_d   = 5'd0;
          end else begin
            nib_d = nib_q + 3'd1;
          end
        end
        StSamples: begin
          if (nib_q == 3'd0) begin
            if (bit_i) begin
              nib_d = 3'd1;
            end else begin
              err_d   = 1'b1;
              state_d = StHunt;
              zcnt_d  = 4'd1;
            end
          end else begin
            we_d   = 1'b1;
            addr_d = {slot_q, ch_q, bit_q};
            data_d = bit_i;
            nib_d  = (nib_q == 3'd4) ? 3'd0 : nib_q + 3'd1;
            if (bit_q == 5'd23) begin
              bit_d = 5'd0;
              ch_d  = ch_q + 3'd1;
              if (ch_q == 3'd7) begin
                pend_d  = 1'b1;
                state_d = StSync;
                scnt_d  = 4'd0;
              end
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end
        StSync: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd0) begin
            if (!bit_i) begin
              err_d   = 1'b1;
              state_d = StHunt;
              zcnt_d  = 4'd1;
            end
          end else if (scnt_q <= 4'd10) begin
            if (bit_i) begin
              err_d   = 1'b1;
              state_d = StHunt;
              zcnt_d  = 4'd0;
            end
          end else if (bit_i) begin
            state_d = StUser;
            nib_d   = 3'd1;
          end else begin
            err_d   = 1'b1;
            state_d = StHunt;
            zcnt_d  = 4'd11;
          end
        end
        default: begin
          state_d = StHunt;
        end
      endcase
    end
  end

  // Commit trails the final RAM write by one cycle.
  always_comb begin
    slot_d  = slot_q;
    idx_d   = idx_q;
    ubits_d = ubits_q;
    done_d  = pend_q;
    good_d  = good_q;
    lock_d  = lock_q;
    if (pend_q) begin
      idx_d   = slot_q;
      ubits_d = user_q;
      slot_d  = slot_q + 1'b1;
      good_d  = 1'b1;
      if (good_q) begin
        lock_d = 1'b1;
      end
    end
    if (err_d) begin
      good_d = 1'b0;
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StHunt;
      zcnt_q  <= 4'd0;
      scnt_q  <= 4'd0;
      nib_q   <= 3'd0;
      user_q  <= 4'd0;
      ch_q    <= 3'd0;
      bit_q   <= 5'd0;
      slot_q  <= SW'(1);
      idx_q   <= '0;
      ubits_q <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= {SW'(1), 8'h00};
      data_q  <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      good_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      zcnt_q  <= zcnt_d;
      scnt_q  <= scnt_d;
      nib_q   <= nib_d;
      user_q  <= user_d;
      ch_q    <= ch_d;
      bit_q   <= bit_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      ubits_q <= ubits_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      err_q   <= err_d;
      good_q  <= good_d;
      lock_q  <= lock_d;
    end
  end

  assign ram_write_addr_o      = addr_q;
  assign ram_data_o            = data_q;
  assign ram_we_o              = we_q;
  assign last_good_frame_idx_o = idx_q;
  assign user_bits_o           = ubits_q;
  assign frame_done_o          = done_q;
  assign frame_error_o         = err_q;
  assign locked_o              = lock_q;

endmodule

// File: tb/tb_adat_decoder.sv
// Bench for adat_decoder: builds ADAT bitstreams from the frame format and
// scores RAM writes, commits and errors against a frame-level model.
module tb_adat_decoder;
  localparam int CB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_in;
  logic          bv;
  logic [CB+7:0] addr;
  logic          data;
  logic          we;
  logic [CB-1:0] idx;
  logic [3:0]    ubits;
  logic          done;
  logic          ferr;
  logic          locked;

  adat_decoder #(.CIRC_BUF_BITS(CB)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .bit_i                 (bit_in),
    .bit_valid_i           (bv),
    .ram_write_addr_o      (addr),
    .ram_data_o            (data),
    .ram_we_o              (we),
    .last_good_frame_idx_o (idx),
    .user_bits_o           (ubits),
    .frame_done_o          (done),
    .frame_error_o         (ferr),
    .locked_o              (locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we_cyc = -100;
  int err_seen = 0;
  int err_exp = 0;
  int m_slot;
  int m_good;
  int gfix;
  logic [23:0]   smp [8];
  logic [CB+8:0] exp_w [$];
  logic [CB+4:0] exp_d [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we) begin
      last_we_cyc = cyc;
      if (exp_w.size() == 0) chk("unexpected_write", 64'(we), 64'd0);
      else chk("ram_write", 64'({addr, data}), 64'(exp_w.pop_front()));
    end
    if (done) begin
      if (exp_d.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
      else begin
        chk("commit", 64'({locked, idx, ubits}), 64'(exp_d.pop_front()));
        chk("commit_latency", 64'(cyc - last_we_cyc), 64'd1);
      end
    end
    if (ferr) begin
      err_seen++;
      chk("lock_on_error", 64'(locked), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gap();
    if (gfix >= 0) return gfix;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic send_bit(input logic b, input int g);
    bit_in = b;
    bv = 1'b1;
    tick();
    bv = 1'b0;
    bit_in = 1'b0;
    repeat (g) tick();
  endtask

  // lead=1: full 256-bit frame; lead=0: 12 idle zeros then the
  // user separator onward, for acquiring sync from hunt.
  task automatic send_frame(input logic [3:0] u, input bit lead,
                            input int bad_nib, input int stop_at);
    logic [CB-1:0] sl;
    sl = m_slot[CB-1:0];
    if (lead) begin
      send_bit(1'b1, gap());
      repeat (10) send_bit(1'b0, gap());
    end else begin
      repeat (12) send_bit(1'b0, gap());
    end
    send_bit(1'b1, gap());
    for (int i = 0; i < 4; i++) send_bit(u[i], gap());
    for (int k = 0; k < 48; k++) begin
      if (k == bad_nib) begin
        err_exp++;
        m_good = 0;
        send_bit(1'b0, gap());
        return;
      end
      send_bit(1'b1, gap());
      for (int j = 0; j < 4; j++) begin
        int n;
        int c;
        int b;
        logic lk;
        n = 4 * k + j;
        c = n / 24;
        b = n % 24;
        exp_w.push_back({sl, c[2:0], b[4:0], smp[c][b]});
        if (n == 191) begin
          m_good++;
          lk = (m_good >= 2);
          exp_d.push_back({lk, sl, u});
          m_slot = (m_slot + 1) % (1 << CB);
        end
        send_bit(smp[c][b], gap());
        if (n + 1 == stop_at) return;
      end
    end
  endtask

  task automatic rand_samples();
    for (int c = 0; c < 8; c++) smp[c] = 24'($urandom());
  endtask

  task automatic settle(input string tag);
    repeat (8) tick();
    chk({tag, "_writes_left"}, 64'(exp_w.size()), 64'd0);
    chk({tag, "_commits_left"}, 64'(exp_d.size()), 64'd0);
    chk({tag, "_error_count"}, 64'(err_seen), 64'(err_exp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    m_slot = 1;
    m_good = 0;
  endtask

  initial begin
    rst = 1'b1;
    bit_in = 1'b0;
    bv = 1'b0;
    gfix = 0;
    m_slot = 1;
    m_good = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_addr", 64'(addr), 64'(1 << 8));
    chk("rst_idx", 64'(idx), 64'd0);
    chk("rst_user", 64'(ubits), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(ferr), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);

    for (int i = 0; i < 1000; i++) send_bit(1'b0, 0);
    settle("idle");

    gfix = 2;
    for (int c = 0; c < 8; c++) smp[c] = 24'hA5A5A0 + 24'(c);
    send_frame(4'b1010, 1'b0, -1, 192);
    settle("first");
    chk("first_idx", 64'(idx), 64'd1);
    chk("first_user", 64'(ubits), 64'b1010);
    chk("first_locked", 64'(locked), 64'd0);

    gfix = -1;
    rand_samples();
    send_frame(4'($urandom()), 1'b1, -1, 192);
    settle("second");
    chk("second_idx", 64'(idx), 64'd2);
    chk("second_locked", 64'(locked), 64'd1);

    rand_samples();
    send_frame(4'($urandom()), 1'b1, 3 * 6 + 2, 192);
    settle("bad");
    chk("bad_idx_hold", 64'(idx), 64'd2);
    chk("bad_locked", 64'(locked), 64'd0);
    rand_samples();
    send_frame(4'b0110, 1'b0, -1, 192);
    settle("recover");
    chk("recover_idx", 64'(idx), 64'd3);
    chk("recover_user", 64'(ubits), 64'b0110);
    chk("recover_locked", 64'(locked), 64'd0);

    do_reset();
    for (int f = 0; f < 10; f++) begin
      rand_samples();
      send_frame(4'($urandom()), f != 0, -1, 192);
    end
    settle("wrap");
    chk("wrap_idx", 64'(idx), 64'd2);
    chk("wrap_locked", 64'(locked), 64'd1);

    rand_samples();
    send_frame(4'($urandom()), 1'b1, -1, 5 * 24 + 11);
    rst = 1'b1;
    bv = 1'b1;
    bit_in = 1'b1;
    tick();
    rst = 1'b0;
    bv = 1'b0;
    bit_in = 1'b0;
    m_slot = 1;
    m_good = 0;
    chk("midrst_we", 64'(we), 64'd0);
    chk("midrst_idx", 64'(idx), 64'd0);
    chk("midrst_locked", 64'(locked), 64'd0);
    chk("midrst_addr", 64'(addr), 64'(1 << 8));
    settle("midrst");
    rand_samples();
    send_frame(4'b0011, 1'b0, -1, 192);
    settle("resync");
    chk("resync_idx", 64'(idx), 64'd1);
    chk("resync_user", 64'(ubits), 64'b0011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
